// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 encryptor: FSM state encodings, S-box size,
// key byte selection and the printable-ASCII window used by the optional plaintext checker.
package rc4_pkg;

  localparam int unsigned S_SIZE = 256;
  localparam int unsigned KEY_W  = 24;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // Key-scheduling sub-FSM (INIT + shuffle).
  typedef enum logic [2:0] {
    KsaIdle,
    KsaInit,
    KsaRdI,
    KsaGetI,
    KsaRdJ,
    KsaGetJ,
    KsaWrI,
    KsaWrJ
  } ksa_state_e;

  // Top-level FSM: idle, key scheduling, PRGA byte loop, done.
  typedef enum logic [3:0] {
    StIdle,
    StKsa,
    StRdI,
    StGetI,
    StRdJ,
    StGetJ,
    StWrI,
    StWrJ,
    StRdF,
    StGetF,
    StWrC,
    StDone
  } enc_state_e;

  // Key byte idx of an nbytes-long key, byte 0 being the most significant one.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key,
                                          input logic [1:0]       idx,
                                          input int unsigned      nbytes);
    logic [KEY_W-1:0] sh;
    sh = key >> (8 * (nbytes - 1 - 32'(idx)));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/rc4_ksa.sv
// RC4 key scheduling: fills S with the identity permutation, then runs the 256-step
// key-dependent shuffle. Started by a one-cycle start_i, reports completion with a
// combinational complete_o during the final write. stop_i freezes it with all enables low.
module rc4_ksa
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [7:0]       s_rdata_i,
  output logic [7:0]       s_address_o,
  output logic [7:0]       s_data_o,
  output logic             s_wren_o,
  output logic             s_rden_o,
  output logic             complete_o
);

  localparam logic [7:0] LastIdx = 8'(S_SIZE - 1);
  localparam logic [1:0] LastKey = 2'(KEY_BYTES - 1);

  ksa_state_e state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [1:0] kidx_q, kidx_d;

  // State and index registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= KsaIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

  // Next state and S-memory requests; nothing advances while stopped.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    kidx_d      = kidx_q;
    s_address_o = '0;
    s_data_o    = '0;
    s_wren_o    = 1'b0;
    s_rden_o    = 1'b0;
    complete_o  = 1'b0;
    if (!stop_i) begin
      unique case (state_q)
        KsaIdle: begin
          if (start_i) begin
            state_d = KsaInit;
            i_d     = '0;
          end
        end
        KsaInit: begin
          s_address_o = i_q;
          s_data_o    = i_q;
          s_wren_o    = 1'b1;
          i_d         = i_q + 8'd1;
          if (i_q == LastIdx) begin
            state_d = KsaRdI;
            j_d     = '0;
            kidx_d  = '0;
          end
        end
        KsaRdI: begin
          s_address_o = i_q;
          s_rden_o    = 1'b1;
          state_d     = KsaGetI;
        end
        KsaGetI: begin
          si_d    = s_rdata_i;
          j_d     = j_q + s_rdata_i + key_byte(key_i, kidx_q, KEY_BYTES);
          state_d = KsaRdJ;
        end
        KsaRdJ: begin
          s_address_o = j_q;
          s_rden_o    = 1'b1;
          state_d     = KsaGetJ;
        end
        KsaGetJ: begin
          sj_d    = s_rdata_i;
          state_d = KsaWrI;
        end
        KsaWrI: begin
          s_address_o = i_q;
          s_data_o    = sj_q;
          s_wren_o    = 1'b1;
          state_d     = KsaWrJ;
        end
        KsaWrJ: begin
          s_address_o = j_q;
          s_data_o    = si_q;
          s_wren_o    = 1'b1;
          if (i_q == LastIdx) begin
            complete_o = 1'b1;
            state_d    = KsaIdle;
            i_d        = '0;
            j_d        = '0;
          end else begin
            i_d     = i_q + 8'd1;
            kidx_d  = (kidx_q == LastKey) ? 2'd0 : kidx_q + 2'd1;
            state_d = KsaRdI;
          end
        end
        default: state_d = KsaIdle;
      endcase
    end
  end

endmodule

// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryptor top: latches the key, runs rc4_ksa over the shared S-memory port, then
// generates the keystream and writes ct[k] = keystream ^ pt[k] for every message byte.
// Optional macro RC4E_CHECK_EN adds a sticky non-printable-plaintext flag (bad_char).
module rc4_encrypt_fsm
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN   = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [23:0]       secret_key,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  output logic              s_rden,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] pt_address,
  output logic              pt_rden,
  input  logic [7:0]        pt_q,
  output logic [ADDR_W-1:0] ct_address,
  output logic [7:0]        ct_data,
  output logic              ct_wren,
  output logic              busy,
  output logic              done,
  output logic              bad_char
);

  localparam logic [ADDR_W-1:0] LastK = ADDR_W'(MSG_LEN - 1);

  enc_state_e        state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        f_q, f_d;
  logic [7:0]        p_q, p_d;
  logic [23:0]       key_q, key_d;

  // Read data is only valid the cycle after a read; keep the last value so a GET state
  // frozen by stop still sees the data its read returned.
  logic       s_vld_q, s_vld_d;
  logic [7:0] s_hold_q, s_hold_d;
  logic       pt_vld_q, pt_vld_d;
  logic [7:0] pt_hold_q, pt_hold_d;
  logic [7:0] s_rdata;
  logic [7:0] pt_rdata;

  assign s_rdata  = s_vld_q ? s_q : s_hold_q;
  assign pt_rdata = pt_vld_q ? pt_q : pt_hold_q;

  logic       ksa_start;
  logic [7:0] ksa_address;
  logic [7:0] ksa_data;
  logic       ksa_wren;
  logic       ksa_rden;
  logic       ksa_complete;

`ifdef RC4E_CHECK_EN
  logic bad_set;
`endif

  rc4_ksa #(
    .KEY_BYTES (KEY_BYTES)
  ) u_ksa (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .start_i     (ksa_start),
    .stop_i      (stop),
    .key_i       (key_q),
    .s_rdata_i   (s_rdata),
    .s_address_o (ksa_address),
    .s_data_o    (ksa_data),
    .s_wren_o    (ksa_wren),
    .s_rden_o    (ksa_rden),
    .complete_o  (ksa_complete)
  );

  // State, PRGA datapath and read-hold registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      f_q       <= '0;
      p_q       <= '0;
      key_q     <= '0;
      s_vld_q   <= 1'b0;
      s_hold_q  <= '0;
      pt_vld_q  <= 1'b0;
      pt_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      f_q       <= f_d;
      p_q       <= p_d;
      key_q     <= key_d;
      s_vld_q   <= s_vld_d;
      s_hold_q  <= s_hold_d;
      pt_vld_q  <= pt_vld_d;
      pt_hold_q <= pt_hold_d;
    end
  end

  // Next state, memory port mux and outputs; stop freezes state with every enable low.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    p_d        = p_q;
    key_d      = key_q;
    ksa_start  = 1'b0;
    s_address  = '0;
    s_data     = '0;
    s_wren     = 1'b0;
    s_rden     = 1'b0;
    pt_address = '0;
    pt_rden    = 1'b0;
    ct_address = '0;
    ct_data    = '0;
    ct_wren    = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle) && (state_q != StDone);
`ifdef RC4E_CHECK_EN
    bad_set    = 1'b0;
`endif
    if (!stop) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ksa_start = 1'b1;
            key_d     = secret_key;
            state_d   = StKsa;
          end
        end
        StKsa: begin
          s_address = ksa_address;
          s_data    = ksa_data;
          s_wren    = ksa_wren;
          s_rden    = ksa_rden;
          if (ksa_complete) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = StRdI;
          end
        end
        StRdI: begin
          s_address = i_q + 8'd1;
          s_rden    = 1'b1;
          i_d       = i_q + 8'd1;
          state_d   = StGetI;
        end
        StGetI: begin
          si_d    = s_rdata;
          j_d     = j_q + s_rdata;
          state_d = StRdJ;
        end
        StRdJ: begin
          s_address = j_q;
          s_rden    = 1'b1;
          state_d   = StGetJ;
        end
        StGetJ: begin
          sj_d    = s_rdata;
          state_d = StWrI;
        end
        StWrI: begin
          s_address = i_q;
          s_data    = sj_q;
          s_wren    = 1'b1;
          state_d   = StWrJ;
        end
        StWrJ: begin
          s_address = j_q;
          s_data    = si_q;
          s_wren    = 1'b1;
          state_d   = StRdF;
        end
        StRdF: begin
          s_address  = si_q + sj_q;
          s_rden     = 1'b1;
          pt_address = k_q;
          pt_rden    = 1'b1;
          state_d    = StGetF;
        end
        StGetF: begin
          f_d     = s_rdata;
          p_d     = pt_rdata;
`ifdef RC4E_CHECK_EN
          bad_set = (pt_rdata < PRINT_LO) || (pt_rdata > PRINT_HI);
`endif
          state_d = StWrC;
        end
        StWrC: begin
          ct_address = k_q;
          ct_data    = f_q ^ p_q;
          ct_wren    = 1'b1;
          if (k_q == LastK) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + ADDR_W'(1);
            state_d = StRdI;
          end
        end
        StDone: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    s_vld_d   = s_rden;
    s_hold_d  = s_rdata;
    pt_vld_d  = pt_rden;
    pt_hold_d = pt_rdata;
  end

`ifdef RC4E_CHECK_EN
  logic bad_q, bad_d;

  // Sticky flag, cleared when a new run is accepted.
  always_comb begin
    bad_d = bad_q;
    if (ksa_start) begin
      bad_d = 1'b0;
    end else if (bad_set) begin
      bad_d = 1'b1;
    end
  end

  // Flag register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bad_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
    end
  end

  assign bad_char = bad_q;
`else
  assign bad_char = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Randomised scoreboard bench for rc4_encrypt_fsm: a plain RC4 reference model fills the
// expected ciphertext queue, a monitor pops it on every ciphertext write.
`timescale 1ns/1ps
module tb_rc4_encrypt_fsm;

  localparam int unsigned MsgLen   = 32;
  localparam int unsigned AddrW    = 5;
  localparam int unsigned KeyBytes = 3;
  localparam int unsigned Lat      = 256 + 6 * 256 + 9 * MsgLen + 1;

  localparam logic [7:0] KatPt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65,
                                       8'h78, 8'h74};
  localparam logic [7:0] KatCt [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF,
                                       8'h0A, 8'hD3};

  logic             clk = 1'b0;
  logic             reset_n, start, stop;
  logic [23:0]      secret_key;
  logic [7:0]       s_address, s_data, s_q;
  logic             s_wren, s_rden;
  logic [AddrW-1:0] pt_address, ct_address;
  logic             pt_rden, ct_wren;
  logic [7:0]       pt_q, ct_data;
  logic             busy, done, bad_char;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [MsgLen];
  logic [7:0] ct_mem [MsgLen];

  logic [AddrW+7:0] exp_q[$];
  bit               exp_bad;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  rc4_encrypt_fsm #(
    .MSG_LEN   (MsgLen),
    .ADDR_W    (AddrW),
    .KEY_BYTES (KeyBytes)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .secret_key (secret_key),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .s_rden     (s_rden),
    .s_q        (s_q),
    .pt_address (pt_address),
    .pt_rden    (pt_rden),
    .pt_q       (pt_q),
    .ct_address (ct_address),
    .ct_data    (ct_data),
    .ct_wren    (ct_wren),
    .busy       (busy),
    .done       (done),
    .bad_char   (bad_char)
  );

  // Synchronous memories: read data valid the cycle after the enable.
  initial begin
    s_q  = '0;
    pt_q = '0;
  end
  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_data;
    if (s_rden) s_q <= s_mem[s_address];
    if (pt_rden) pt_q <= pt_mem[pt_address];
    if (ct_wren) ct_mem[ct_address] <= ct_data;
  end

  // Monitor: every ciphertext write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [AddrW+7:0] e;
    if (ct_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ct_write unexpected addr=%0d data=%02h required none", ct_address, ct_data);
      end else begin
        e = exp_q.pop_front();
        if ({ct_address, ct_data} !== e) begin
          errors++;
          $display("FAIL ct_write actual addr=%0d data=%02h required addr=%0d data=%02h",
                   ct_address, ct_data, e[AddrW+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {23'd0, s_address, s_data, s_wren, s_rden, pt_address, pt_rden, ct_address, ct_data,
            ct_wren, busy, done, bad_char};
  endfunction

  // Textbook RC4 over pt_mem; pushes the expected ciphertext writes.
  function automatic void model_push(input logic [23:0] key);
    int         s [256];
    int         i, j, t;
    logic [7:0] ks, kb;
    logic [23:0] sh;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      sh = key >> (8 * (KeyBytes - 1 - (n % KeyBytes)));
      kb = sh[7:0];
      j = (j + s[n] + int'(kb)) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    exp_bad = 1'b0;
    for (int n = 0; n < MsgLen; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks = 8'(s[(s[i] + s[j]) % 256]);
      exp_q.push_back({n[AddrW-1:0], ks ^ pt_mem[n]});
`ifdef RC4E_CHECK_EN
      if (pt_mem[n] < 8'h20 || pt_mem[n] > 8'h7E) exp_bad = 1'b1;
`endif
    end
  endfunction

  task automatic fill_pt();
    for (int n = 0; n < MsgLen; n++) pt_mem[n] = 8'($urandom_range(32, 126));
  endtask

  // mode: 0 plain, 1 stop 10 cycles mid-shuffle, 2 random stops, 3 start pulse while busy,
  // 4 reset mid-PRGA (aborts run).
  task automatic run(input logic [23:0] key, input int mode);
    int c, stops;
    bit r, got;
    exp_q.delete();
    model_push(key);
    secret_key = key;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    c     = 0;
    stops = 0;
    got   = 1'b0;
    while (c < int'(Lat) + 2000) begin
      c++;
      case (mode)
        1:       r = (c >= 400 && c < 410);
        2:       r = ($urandom_range(0, 7) == 0);
        default: r = 1'b0;
      endcase
      stop = r;
      if (r) stops++;
      if (mode == 3) begin
        start = (c == 500);
        if (c == 500) secret_key = ~key;
      end
      if (mode == 4 && c == 1800) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("outputs_after_midrun_reset", all_outputs(), 0);
        reset_n = 1'b1;
        exp_q.delete();
        return;
      end
      #1;
      if (r) check("quiet_during_stop", {s_wren, s_rden, pt_rden, ct_wren, done}, 0);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    stop  = 1'b0;
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", c);
    end
    check("latency", c, Lat + stops);
    check("busy_in_done_cycle", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", {busy, done}, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("bad_char", bad_char, exp_bad);
  endtask

  initial begin
    logic [23:0] k;
    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    secret_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer key "Key", plaintext "Plaintext" in the first nine bytes.
    fill_pt();
    for (int n = 0; n < 9; n++) pt_mem[n] = KatPt[n];
    run(24'h4B6579, 0);
    for (int n = 0; n < 9; n++) check($sformatf("kat_ct[%0d]", n), ct_mem[n], KatCt[n]);

    fill_pt();
    run(24'h000000, 0);

    fill_pt();
    run(24'($urandom), 1);

    fill_pt();
    k = 24'($urandom);
    run(k, 4);
    run(k, 0);

    fill_pt();
    run(24'($urandom), 3);

    fill_pt();
    run(24'($urandom), 2);

    fill_pt();
    pt_mem[4] = 8'h0A;
    run(24'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
